hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised successor to the pipeline hazard logic for the 5-stage MIPS core. Combines load-use stall detection, EX/MEM and MEM/WB forwarding select, multi-cycle control-flush sequencing and memory-wait freeze in one FSM. It drives the stage enables and flushes of the IF/ID, ID/EX and EX/MEM latches and the PC. It sits beside the datapath.

Parameters:
REG_AW, 5, register address width
FLUSH_CYCLES, 1, bubbles inserted after a taken branch/jump (1..7)
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3)

Ports:
CLK  in  1  core clock
RST  in  1  synchronous active-high reset
ifid_rs, ifid_rt  in  REG_AW  source regs of instruction in ID
idex_rs, idex_rt  in  REG_AW  source regs of instruction in EX
idex_dren  in  1  EX instruction is a load
idex_wsel  in  REG_AW  EX destination reg
exmem_wen, memwb_wen  in  1  MEM/WB stage writes regfile
exmem_wsel, memwb_wsel  in  REG_AW  MEM/WB destination regs
pcsrc  in  2  from EX: 00 PC+4, 01 JR, 10 branch taken, 11 J/JAL
ihit, dhit  in  1  memory ready
dmem_req  in  1  MEM stage has dren|dwen
pc_en, ifid_en, idex_en, exmem_en  out  1  stage advance enables
ifid_flush, idex_flush  out  1  zero latch on next edge
fwd_a, fwd_b  out  2  ALU operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
state_o  out  2  current FSM state (debug)

Behaviour:
- States: RUN=00, LU_STALL=01, FLUSH=10, MEM_WAIT=11. Reset: state RUN, counter 0, all enables 1, flushes 0, fwd 00, state_o 00.
- Fixed priority per cycle: RST > mem freeze > control flush > load-use > run.
- Mem freeze: (dmem_req & !dhit) | (!dmem_req & !ihit). All enables 0, flushes 0. Enter MEM_WAIT and hold counter. On release, return to the saved state (RUN/LU_STALL/FLUSH) with the counter unchanged.
- Control flush: pcsrc!=00 in RUN or LU_STALL. ifid_flush=idex_flush=1 that cycle with enables 1, so the PC loads the target. If FLUSH_CYCLES>1, go to FLUSH with count=FLUSH_CYCLES-1. In FLUSH, ifid_flush=1 and pc_en=1 each cycle; decrement; exit to RUN at 0. A flush pre-empts a pending load-use stall; the counter is cleared.
- Load-use: idex_dren & idex_wsel!=0 & (idex_wsel==ifid_rs | idex_wsel==ifid_rt). pc_en=ifid_en=0, idex_flush=1. Stay in LU_STALL for LU_STALL_CYCLES cycles total, then RUN. Re-detection after exit starts a new stall.
- Forwarding, combinational, evaluated every state: fwd_a=10 if exmem_wen & exmem_wsel!=0 & exmem_wsel==idex_rs; else 01 on the same condition using memwb_*; else 00. fwd_b is the same using idex_rt. EX/MEM beats MEM/WB. Forwarding of reg 0 is never generated.
- Stage enables and flushes are combinational from state plus inputs. State and counter are registered. Minimum latency of one cycle from hazard to FSM state.
- RST asserted mid-stall or mid-flush: next edge returns to reset values; no pending bubble survives.

Optional Feature:
HAZARD_STATS_EN: adds outputs stall_cnt[31:0] and flush_cnt[31:0]. stall_cnt increments on each LU_STALL or MEM_WAIT cycle; flush_cnt increments once per control-flush event. Both saturate at all-ones and clear on RST. Without the macro, the ports and counters are absent.

Decomposition:
cpu_types_pkg gains hz_state_t (2-bit enum), fwd_sel_t (FWD_RF, FWD_WB, FWD_MEM) and the pcsrc codes PC_NEXT, PC_JR, PC_BR, PC_J. A natural sub-module is fwd_select, a purely combinational forwarding comparator instantiated twice for operands a and b.

Test Plan:
- lw $3 in EX, ID reads rs=3 -> pc_en=ifid_en=0, idex_flush=1 for exactly LU_STALL_CYCLES cycles, then RUN; with idex_wsel=0 -> no stall.
- exmem_wen=1, exmem_wsel=4, memwb_wen=1, memwb_wsel=4, idex_rs=4 -> fwd_a=10; drop exmem_wen -> fwd_a=01; idex_rt=7 -> fwd_b=00.
- FLUSH_CYCLES=3, pcsrc=10 -> cycle 0 both flushes=1; cycles 1-2 ifid_flush=1 in FLUSH; cycle 3 RUN.
- pcsrc=11 with load-use present in the same cycle -> flush wins, no LU_STALL entered.
- In FLUSH with count 1, dmem_req=1, dhit=0 for 4 cycles -> all enables 0, state_o=11; on dhit -> FLUSH resumes with count 1.
- RST raised in LU_STALL -> next cycle state_o=00, all enables 1; with HAZARD_STATS_EN, counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller.
// Optional macro HAZARD_STATS_EN (see hazard_ctrl.sv) uses sat_inc32 below.
package hazard_ctrl_pkg;

    // Controller FSM states; the encoding is visible on the state_o debug port.
    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_LU_STALL = 2'b01,
        HZ_FLUSH    = 2'b10,
        HZ_MEM_WAIT = 2'b11
    } hz_state_t;

    // ALU operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Next-PC source codes produced by the EX stage.
    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_JR   = 2'b01;
    localparam logic [1:0] PC_BR   = 2'b10;
    localparam logic [1:0] PC_J    = 2'b11;

    // Bubble counter width; covers up to 7 remaining bubbles.
    localparam int CNT_W = 3;

    // Saturating increment used by the optional event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: datapath <-> hazard controller signal bundle.
// The master side is the datapath, the slave side is hazard_ctrl.
// With HAZARD_STATS_EN defined the bundle also carries stall_cnt/flush_cnt.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] ifid_rs, ifid_rt;
    logic [REG_AW-1:0] idex_rs, idex_rt;
    logic              idex_dren;
    logic [REG_AW-1:0] idex_wsel;
    logic              exmem_wen, memwb_wen;
    logic [REG_AW-1:0] exmem_wsel, memwb_wsel;
    logic [1:0]        pcsrc;
    logic              ihit, dhit, dmem_req;

    logic              pc_en, ifid_en, idex_en, exmem_en;
    logic              ifid_flush, idex_flush;
    logic [1:0]        fwd_a, fwd_b;
    logic [1:0]        state_o;
`ifdef HAZARD_STATS_EN
    logic [31:0]       stall_cnt, flush_cnt;

    modport master (
        output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_dren, idex_wsel,
               exmem_wen, memwb_wen, exmem_wsel, memwb_wsel, pcsrc,
               ihit, dhit, dmem_req,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               fwd_a, fwd_b, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_dren, idex_wsel,
               exmem_wen, memwb_wen, exmem_wsel, memwb_wsel, pcsrc,
               ihit, dhit, dmem_req,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               fwd_a, fwd_b, state_o, stall_cnt, flush_cnt
    );
`else
    modport master (
        output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_dren, idex_wsel,
               exmem_wen, memwb_wen, exmem_wsel, memwb_wsel, pcsrc,
               ihit, dhit, dmem_req,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               fwd_a, fwd_b, state_o
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_dren, idex_wsel,
               exmem_wen, memwb_wen, exmem_wsel, memwb_wsel, pcsrc,
               ihit, dhit, dmem_req,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               fwd_a, fwd_b, state_o
    );
`endif

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// hazard_ctrl_fwd_select: combinational forwarding comparator for one ALU operand.
// The younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
module hazard_ctrl_fwd_select
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              exmem_wen,
    input  logic [REG_AW-1:0] exmem_wsel,
    input  logic              memwb_wen,
    input  logic [REG_AW-1:0] memwb_wsel,
    output fwd_sel_t          sel
);
    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_wen && (exmem_wsel != '0) && (exmem_wsel == src);
    assign memwb_hit = memwb_wen && (memwb_wsel != '0) && (memwb_wsel == src);

    // Priority select: newest producer first.
    always_comb begin
        if (exmem_hit) begin
            sel = FWD_MEM;
        end else if (memwb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/freeze sequencing and operand forwarding for the
// 5-stage MIPS pipeline. Stage enables and flushes are combinational from the
// registered state plus the current hazard inputs.
// Optional feature macro: HAZARD_STATS_EN (adds stall_cnt/flush_cnt counters).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int FLUSH_CYCLES    = 1,
    parameter int LU_STALL_CYCLES = 1
) (
    input logic          CLK,
    input logic          RST,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0] ST_RUN      = 2'(HZ_RUN);
    localparam logic [1:0] ST_LU_STALL = 2'(HZ_LU_STALL);
    localparam logic [1:0] ST_FLUSH    = 2'(HZ_FLUSH);
    localparam logic [1:0] ST_MEM_WAIT = 2'(HZ_MEM_WAIT);

    // Remaining bubbles after the cycle that detects the hazard.
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LU_RELOAD    = CNT_W'(LU_STALL_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       saved_q, saved_d;   // state to resume after a memory freeze
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic     mem_freeze;
    logic     redirect;
    logic     ctrl_flush;
    logic     load_use;
    fwd_sel_t fwd_a_sel, fwd_b_sel;

    assign mem_freeze = (hz.dmem_req && !hz.dhit) || (!hz.dmem_req && !hz.ihit);

    // Decode whether EX is redirecting the PC.
    always_comb begin
        redirect = 1'b0;
        case (hz.pcsrc)
            PC_JR, PC_BR, PC_J: redirect = 1'b1;
            PC_NEXT:            redirect = 1'b0;
        endcase
    end

    // A redirect is only honoured from RUN or LU_STALL; it pre-empts a stall.
    assign ctrl_flush = redirect && ((state_q == ST_RUN) || (state_q == ST_LU_STALL));

    assign load_use = hz.idex_dren && (hz.idex_wsel != '0) &&
                      ((hz.idex_wsel == hz.ifid_rs) || (hz.idex_wsel == hz.ifid_rt));

    // Next-state and stage-control decode in priority order: freeze > flush > load-use.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        saved_d       = saved_q;
        cnt_d         = cnt_q;
        hz.pc_en      = 1'b1;
        hz.ifid_en    = 1'b1;
        hz.idex_en    = 1'b1;
        hz.exmem_en   = 1'b1;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;

        if (mem_freeze) begin
            {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en} = 4'b0000;
            state_d = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                saved_d = state_q;
            end
        end else begin
            case (state_q)
                ST_MEM_WAIT: begin
                    // Release cycle: pipeline still held, resume on the next edge.
                    {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en} = 4'b0000;
                    state_d = saved_q;
                end
                ST_FLUSH: begin
                    hz.ifid_flush = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (ctrl_flush) begin
                        hz.ifid_flush = 1'b1;
                        hz.idex_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_RELOAD;
                        end else begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end
                    end else if (state_q == ST_LU_STALL) begin
                        hz.pc_en      = 1'b0;
                        hz.ifid_en    = 1'b0;
                        hz.idex_flush = 1'b1;
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else if (load_use) begin
                        hz.pc_en      = 1'b0;
                        hz.ifid_en    = 1'b0;
                        hz.idex_flush = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            state_d = ST_LU_STALL;
                            cnt_d   = LU_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    // FSM state, resume state and bubble counter registers.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (RST) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    hazard_ctrl_fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src        (hz.idex_rs),
        .exmem_wen  (hz.exmem_wen),
        .exmem_wsel (hz.exmem_wsel),
        .memwb_wen  (hz.memwb_wen),
        .memwb_wsel (hz.memwb_wsel),
        .sel        (fwd_a_sel)
    );

    hazard_ctrl_fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src        (hz.idex_rt),
        .exmem_wen  (hz.exmem_wen),
        .exmem_wsel (hz.exmem_wsel),
        .memwb_wen  (hz.memwb_wen),
        .memwb_wsel (hz.memwb_wsel),
        .sel        (fwd_b_sel)
    );

    assign hz.fwd_a   = fwd_a_sel;
    assign hz.fwd_b   = fwd_b_sel;
    assign hz.state_o = state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        flush_evt;
    logic        stall_cyc;

    assign flush_evt = ctrl_flush && !mem_freeze;
    assign stall_cyc = (state_q == ST_LU_STALL) || (state_q == ST_MEM_WAIT);

    // Saturating event counters for performance debug.
    always_comb begin
        stall_cnt_d = sat_inc32(stall_cnt_q, stall_cyc);
        flush_cnt_d = sat_inc32(flush_cnt_q, flush_evt);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl (FLUSH_CYCLES=3,
// LU_STALL_CYCLES=2). Table vectors, hand sequences, then random stimulus
// against a bubble-counting reference model.
module tb_hazard_ctrl;

    localparam int FC = 3;
    localparam int LC = 2;

    typedef struct packed {
        logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_wsel, exmem_wsel, memwb_wsel;
        logic       idex_dren, exmem_wen, memwb_wen, ihit, dhit, dmem_req, rst;
        logic [1:0] pcsrc;
    } vin_t;

    typedef struct {
        vin_t        v;
        logic [11:0] exp;
    } tv_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl_if #(.REG_AW(5)) hz_if ();

    hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(FC), .LU_STALL_CYCLES(LC)) dut (
        .CLK (clk),
        .RST (rst),
        .hz  (hz_if)
    );

    always #5 clk = ~clk;

    // Reference model: remaining bubbles and a frozen flag; counters keep their
    // value while frozen, so no resume state is needed.
    int          m_flush_left = 0;
    int          m_stall_left = 0;
    bit          m_wait = 1'b0;
    longint      m_stall_cnt = 0;
    longint      m_flush_cnt = 0;
    logic [11:0] m_exp;
    logic [31:0] m_exp_stall, m_exp_flush;

    function automatic logic [11:0] pk(input logic pc, ifd, idx, exm, ifl, xfl,
                                       input logic [1:0] fa, fb, st);
        return {pc, ifd, idx, exm, ifl, xfl, fa, fb, st};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input vin_t v);
        if (src == 5'd0) return 2'b00;
        if (v.exmem_wen && v.exmem_wsel == src) return 2'b10;
        if (v.memwb_wen && v.memwb_wsel == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic longint sat(input longint x);
        return (x < 64'hFFFF_FFFF) ? x + 1 : x;
    endfunction

    task automatic model_step(input vin_t v);
        logic       frz, lu, pc, ifd, idx, exm, ifl, xfl;
        logic [1:0] st;
        frz = (v.dmem_req && !v.dhit) || (!v.dmem_req && !v.ihit);
        lu  = v.idex_dren && (v.idex_wsel != 5'd0) &&
              (v.idex_wsel == v.ifid_rs || v.idex_wsel == v.ifid_rt);
        st  = m_wait ? 2'd3 : (m_flush_left > 0) ? 2'd2 : (m_stall_left > 0) ? 2'd1 : 2'd0;
        m_exp_stall = 32'(m_stall_cnt);
        m_exp_flush = 32'(m_flush_cnt);
        if (st == 2'd1 || st == 2'd3) m_stall_cnt = sat(m_stall_cnt);
        {pc, ifd, idx, exm} = 4'b1111;
        {ifl, xfl} = 2'b00;
        if (frz) begin
            {pc, ifd, idx, exm} = 4'b0000;
            m_wait = 1'b1;
        end else if (m_wait) begin
            {pc, ifd, idx, exm} = 4'b0000;
            m_wait = 1'b0;
        end else if (m_flush_left > 0) begin
            ifl = 1'b1;
            m_flush_left--;
        end else if (v.pcsrc != 2'b00) begin
            ifl = 1'b1;
            xfl = 1'b1;
            m_flush_left = FC - 1;
            m_stall_left = 0;
            m_flush_cnt  = sat(m_flush_cnt);
        end else if (m_stall_left > 0) begin
            pc = 1'b0; ifd = 1'b0; xfl = 1'b1;
            m_stall_left--;
        end else if (lu) begin
            pc = 1'b0; ifd = 1'b0; xfl = 1'b1;
            m_stall_left = LC - 1;
        end
        m_exp = pk(pc, ifd, idx, exm, ifl, xfl, ref_fwd(v.idex_rs, v), ref_fwd(v.idex_rt, v), st);
        if (v.rst) begin
            m_flush_left = 0;
            m_stall_left = 0;
            m_wait       = 1'b0;
            m_stall_cnt  = 0;
            m_flush_cnt  = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vin_t idle();
        vin_t v;
        v = '0;
        v.ihit = 1'b1;
        v.dhit = 1'b1;
        return v;
    endfunction

    function automatic vin_t mkv(input logic [4:0] ifrs, ifrt, exrs, exrt,
                                 input logic dren, input logic [4:0] wsel,
                                 input logic exw, input logic [4:0] exsel,
                                 input logic wbw, input logic [4:0] wbsel);
        vin_t v;
        v = idle();
        v.ifid_rs = ifrs; v.ifid_rt = ifrt; v.idex_rs = exrs; v.idex_rt = exrt;
        v.idex_dren = dren; v.idex_wsel = wsel;
        v.exmem_wen = exw; v.exmem_wsel = exsel;
        v.memwb_wen = wbw; v.memwb_wsel = wbsel;
        return v;
    endfunction

    // Drive one cycle at the falling edge, sample mid-cycle, advance the model.
    task automatic cyc(input vin_t v, output logic [11:0] act);
        @(negedge clk);
        hz_if.ifid_rs = v.ifid_rs;      hz_if.ifid_rt = v.ifid_rt;
        hz_if.idex_rs = v.idex_rs;      hz_if.idex_rt = v.idex_rt;
        hz_if.idex_dren = v.idex_dren;  hz_if.idex_wsel = v.idex_wsel;
        hz_if.exmem_wen = v.exmem_wen;  hz_if.exmem_wsel = v.exmem_wsel;
        hz_if.memwb_wen = v.memwb_wen;  hz_if.memwb_wsel = v.memwb_wsel;
        hz_if.pcsrc = v.pcsrc;          hz_if.ihit = v.ihit;
        hz_if.dhit = v.dhit;            hz_if.dmem_req = v.dmem_req;
        rst = v.rst;
        #1;
        act = {hz_if.pc_en, hz_if.ifid_en, hz_if.idex_en, hz_if.exmem_en,
               hz_if.ifid_flush, hz_if.idex_flush, hz_if.fwd_a, hz_if.fwd_b, hz_if.state_o};
        model_step(v);
    endtask

    initial begin
        tv_t         tv[9];
        vin_t        v, vr, lu, fz;
        logic [11:0] act;
        logic [11:0] run_idle, fl_det, fl_st, lu_det, lu_st, frz2, frz3;

        run_idle = pk(1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);
        fl_det   = pk(1, 1, 1, 1, 1, 1, 2'b00, 2'b00, 2'b00);
        fl_st    = pk(1, 1, 1, 1, 1, 0, 2'b00, 2'b00, 2'b10);
        lu_det   = pk(0, 0, 1, 1, 0, 1, 2'b00, 2'b00, 2'b00);
        lu_st    = pk(0, 0, 1, 1, 0, 1, 2'b00, 2'b00, 2'b01);
        frz2     = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
        frz3     = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11);

        // Single-cycle vectors from RUN: forwarding and non-stalling cases.
        tv[0].v = mkv(0, 0, 4, 7, 0, 0, 1, 4, 1, 4);  tv[0].exp = pk(1,1,1,1,0,0,2'b10,2'b00,0);
        tv[1].v = mkv(0, 0, 4, 7, 0, 0, 0, 4, 1, 4);  tv[1].exp = pk(1,1,1,1,0,0,2'b01,2'b00,0);
        tv[2].v = mkv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);  tv[2].exp = pk(1,1,1,1,0,0,2'b00,2'b00,0);
        tv[3].v = mkv(0, 0, 6, 5, 0, 0, 1, 5, 1, 6);  tv[3].exp = pk(1,1,1,1,0,0,2'b01,2'b10,0);
        tv[4].v = mkv(0, 0, 9, 9, 0, 0, 1, 9, 0, 9);  tv[4].exp = pk(1,1,1,1,0,0,2'b10,2'b10,0);
        tv[5].v = mkv(0, 0, 9, 9, 0, 0, 0, 9, 0, 9);  tv[5].exp = pk(1,1,1,1,0,0,2'b00,2'b00,0);
        tv[6].v = mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);  tv[6].exp = run_idle;
        tv[7].v = mkv(6, 7, 0, 0, 1, 5, 0, 0, 0, 0);  tv[7].exp = run_idle;
        tv[8].v = mkv(3, 0, 0, 0, 0, 3, 0, 0, 0, 0);  tv[8].exp = run_idle;

        v = idle();
        v.rst = 1'b1;
        rst = 1'b1;
        hz_if.ihit = 1'b1; hz_if.dhit = 1'b1; hz_if.dmem_req = 1'b0; hz_if.pcsrc = 2'b00;
        cyc(v, act);
        cyc(v, act);
        cyc(idle(), act);
        check("reset_state", 32'(act), 32'(run_idle));

        for (int i = 0; i < 9; i++) begin
            cyc(tv[i].v, act);
            check($sformatf("vec%0d", i), 32'(act), 32'(tv[i].exp));
        end

        // Load-use: stall for exactly LC cycles, then run.
        lu = mkv(3, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        cyc(lu, act);       check("lu_detect", 32'(act), 32'(lu_det));
        cyc(idle(), act);   check("lu_state",  32'(act), 32'(lu_st));
        cyc(idle(), act);   check("lu_exit",   32'(act), 32'(run_idle));

        // Branch taken: both flushes, then FC-1 cycles in FLUSH, then RUN.
        v = idle(); v.pcsrc = 2'b10;
        cyc(v, act);        check("br_detect", 32'(act), 32'(fl_det));
        cyc(idle(), act);   check("br_flush1", 32'(act), 32'(fl_st));
        cyc(idle(), act);   check("br_flush2", 32'(act), 32'(fl_st));
        cyc(idle(), act);   check("br_exit",   32'(act), 32'(run_idle));

        // Jump with a simultaneous load-use: flush wins, LU_STALL never entered.
        v = lu; v.pcsrc = 2'b11;
        cyc(v, act);        check("j_lu_detect", 32'(act), 32'(fl_det));
        cyc(idle(), act);   check("j_lu_flush",  32'(act), 32'(fl_st));
        cyc(idle(), act);
        cyc(idle(), act);   check("j_lu_exit",   32'(act), 32'(run_idle));

        // Data-memory freeze on the last FLUSH cycle, then resume with one bubble left.
        v = idle(); v.pcsrc = 2'b10;
        fz = idle(); fz.dmem_req = 1'b1; fz.dhit = 1'b0;
        cyc(v, act);
        cyc(idle(), act);
        cyc(fz, act);       check("frz_enter", 32'(act), 32'(frz2));
        for (int i = 0; i < 3; i++) begin
            cyc(fz, act);   check($sformatf("frz_hold%0d", i), 32'(act), 32'(frz3));
        end
        v = idle(); v.dmem_req = 1'b1;
        cyc(v, act);        check("frz_release", 32'(act), 32'(frz3));
        cyc(idle(), act);   check("frz_resume",  32'(act), 32'(fl_st));
        cyc(idle(), act);   check("frz_done",    32'(act), 32'(run_idle));

        // Reset while in LU_STALL.
        cyc(lu, act);
        v = idle(); v.rst = 1'b1;
        cyc(v, act);        check("rst_in_lu", 32'(act), 32'(lu_st));
        cyc(idle(), act);   check("rst_after", 32'(act), 32'(run_idle));
`ifdef HAZARD_STATS_EN
        check("rst_stall_cnt", hz_if.stall_cnt, 32'd0);
        check("rst_flush_cnt", hz_if.flush_cnt, 32'd0);
`endif

        // Random stimulus against the reference model.
        v = idle(); v.rst = 1'b1;
        cyc(v, act);
        for (int n = 0; n < 600; n++) begin
            vr.ifid_rs    = 5'($urandom_range(0, 3));
            vr.ifid_rt    = 5'($urandom_range(0, 3));
            vr.idex_rs    = 5'($urandom_range(0, 3));
            vr.idex_rt    = 5'($urandom_range(0, 3));
            vr.idex_wsel  = 5'($urandom_range(0, 3));
            vr.exmem_wsel = 5'($urandom_range(0, 3));
            vr.memwb_wsel = 5'($urandom_range(0, 3));
            vr.idex_dren  = 1'($urandom_range(0, 1));
            vr.exmem_wen  = 1'($urandom_range(0, 1));
            vr.memwb_wen  = 1'($urandom_range(0, 1));
            vr.dmem_req   = 1'($urandom_range(0, 1));
            vr.ihit       = 1'($urandom_range(0, 5) != 0);
            vr.dhit       = 1'($urandom_range(0, 5) != 0);
            vr.pcsrc      = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            vr.rst        = 1'($urandom_range(0, 79) == 0);
            cyc(vr, act);
            check("rand", 32'(act), 32'(m_exp));
`ifdef HAZARD_STATS_EN
            check("rand_stall_cnt", hz_if.stall_cnt, m_exp_stall);
            check("rand_flush_cnt", hz_if.flush_cnt, m_exp_flush);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
